// File: rtl/game_countdown.sv
// ============================================================================
// Module   : game_countdown
// Brief    : Whole-second game timer with binary and BCD outputs.
//            Optional macro GAME_BONUS_EN adds BONUS_S seconds per duck hit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module game_countdown #(
  parameter int CLK_HZ  = 65_000_000,
  parameter int MAX_S   = 99,
  parameter int BONUS_S = 5
) (
  input  logic       pclk,
  input  logic       rst_d,
  input  logic [6:0] time_in,
  input  logic [1:0] state_in,
  input  logic       clicked_duck,
  output logic       end_of_time,
  output logic       sec_tick,
  output logic [6:0] seconds_left,
  output logic [7:0] time_bcd
);

  localparam logic [1:0] c_GAME = 2'b10;

  localparam logic [1:0] c_ST_STOP    = 2'd0;
  localparam logic [1:0] c_ST_LOAD    = 2'd1;
  localparam logic [1:0] c_ST_RUN     = 2'd2;
  localparam logic [1:0] c_ST_EXPIRED = 2'd3;

  localparam int                 c_PRESC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(CLK_HZ - 1);
  localparam logic [6:0]         c_MAX_SEC   = 7'(MAX_S);

  logic [1:0]           r_state;
  logic                 r_prev_game;
  logic [c_PRESC_W-1:0] r_presc;

  logic       w_game;
  logic       w_tick;
  logic [6:0] w_load_sec;
  logic [6:0] w_dec_sec;
  logic [7:0] w_dec_bcd;
  logic [6:0] w_run_sec;
  logic [7:0] w_run_bcd;

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [7:0] v8;
    v8 = {1'b0, v};
    return ((v8 / 8'd10) << 4) | (v8 % 8'd10);
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] b);
    if (b[3:0] == 4'd0)
      return {b[7:4] - 4'd1, 4'd9};
    else
      return {b[7:4], b[3:0] - 4'd1};
  endfunction

  assign w_game     = (state_in == c_GAME);
  assign w_tick     = (r_state == c_ST_RUN) && (r_presc == c_PRESC_MAX);
  assign w_load_sec = (time_in > c_MAX_SEC) ? c_MAX_SEC : time_in;

`ifdef GAME_BONUS_EN
  logic [7:0] w_sum;
  logic [6:0] w_bonus_sec;

  always_comb begin
    w_dec_sec   = w_tick ? seconds_left - 7'd1 : seconds_left;
    w_dec_bcd   = w_tick ? bcd_dec(time_bcd) : time_bcd;
    // Bonus is applied on top of a same-cycle decrement, then saturated.
    w_sum       = {1'b0, w_dec_sec} + 8'(BONUS_S);
    w_bonus_sec = (w_sum > {1'b0, c_MAX_SEC}) ? c_MAX_SEC : w_sum[6:0];
    w_run_sec   = clicked_duck ? w_bonus_sec : w_dec_sec;
    w_run_bcd   = clicked_duck ? to_bcd(w_bonus_sec) : w_dec_bcd;
  end
`else
  logic [8:0] w_unused;
  assign w_unused = {clicked_duck, 8'(BONUS_S)};

  always_comb begin
    w_dec_sec = w_tick ? seconds_left - 7'd1 : seconds_left;
    w_dec_bcd = w_tick ? bcd_dec(time_bcd) : time_bcd;
    w_run_sec = w_dec_sec;
    w_run_bcd = w_dec_bcd;
  end
`endif

  always_ff @(posedge pclk) begin
    if (rst_d) begin
      r_state      <= c_ST_STOP;
      // Held as "was GAME" so a GAME level present at reset release is not an entry.
      r_prev_game  <= 1'b1;
      r_presc      <= '0;
      end_of_time  <= 1'b0;
      sec_tick     <= 1'b0;
      seconds_left <= '0;
      time_bcd     <= '0;
    end else begin
      r_prev_game <= w_game;
      sec_tick    <= 1'b0;
      end_of_time <= (r_state == c_ST_EXPIRED) && w_game;

      if (r_state != c_ST_STOP && !w_game) begin
        r_state      <= c_ST_STOP;
        r_presc      <= '0;
        seconds_left <= '0;
        time_bcd     <= '0;
      end else begin
        case (r_state)
          c_ST_STOP: begin
            r_presc      <= '0;
            seconds_left <= '0;
            time_bcd     <= '0;
            if (w_game && !r_prev_game)
              r_state <= c_ST_LOAD;
          end
          c_ST_LOAD: begin
            r_presc      <= '0;
            seconds_left <= w_load_sec;
            time_bcd     <= to_bcd(w_load_sec);
            r_state      <= (w_load_sec == 7'd0) ? c_ST_EXPIRED : c_ST_RUN;
          end
          c_ST_RUN: begin
            r_presc      <= w_tick ? '0 : r_presc + 1'b1;
            sec_tick     <= w_tick;
            seconds_left <= w_run_sec;
            time_bcd     <= w_run_bcd;
            if (w_run_sec == 7'd0)
              r_state <= c_ST_EXPIRED;
          end
          default: begin
            r_presc      <= '0;
            seconds_left <= '0;
            time_bcd     <= '0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_game_countdown.sv
// ============================================================================
// Module   : tb_game_countdown
// Brief    : Directed self-checking bench for game_countdown (CLK_HZ=10).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_game_countdown;

  localparam logic [1:0] c_IDLE  = 2'b00;
  localparam logic [1:0] c_GAME  = 2'b10;
  localparam logic [1:0] c_SCORE = 2'b11;

  logic       pclk = 1'b0;
  logic       rst_d;
  logic [6:0] time_in;
  logic [1:0] state_in;
  logic       clicked_duck;
  logic       end_of_time;
  logic       sec_tick;
  logic [6:0] seconds_left;
  logic [7:0] time_bcd;

  int checks   = 0;
  int failures = 0;

  game_countdown #(.CLK_HZ(10), .MAX_S(99), .BONUS_S(5)) dut (
    .pclk         (pclk),
    .rst_d        (rst_d),
    .time_in      (time_in),
    .state_in     (state_in),
    .clicked_duck (clicked_duck),
    .end_of_time  (end_of_time),
    .sec_tick     (sec_tick),
    .seconds_left (seconds_left),
    .time_bcd     (time_bcd)
  );

  always #5 pclk = ~pclk;

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Steps until sec_tick is seen; n is the number of cycles taken (capped).
  task automatic wait_for_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sec_tick && n < 40);
  endtask

  // Produces an entry edge; returns one cycle after the LOAD cycle.
  task automatic enter_game(input logic [6:0] t);
    time_in  = t;
    state_in = c_IDLE;
    step();
    state_in = c_GAME;
    step();
    step();
  endtask

  task automatic test_reset();
    rst_d = 1'b1; state_in = c_IDLE; time_in = 7'd0; clicked_duck = 1'b0;
    step(); step();
    checks++;
    if ({end_of_time, sec_tick, seconds_left, time_bcd} !== 17'd0) begin
      $display("FAIL reset_outputs got=%h exp=0", {end_of_time, sec_tick, seconds_left, time_bcd});
      failures++;
    end
    rst_d = 1'b0;
    step();
  endtask

  task automatic test_basic_countdown();
    int n;
    enter_game(7'd3);
    checks++;
    if (seconds_left !== 7'd3 || time_bcd !== 8'h03) begin
      $display("FAIL load3 got=%0d/%h exp=3/03", seconds_left, time_bcd); failures++;
    end
    wait_for_tick(n);
    checks++;
    if (n !== 10 || seconds_left !== 7'd2 || time_bcd !== 8'h02) begin
      $display("FAIL tick_to_2 cycles=%0d sec=%0d bcd=%h exp=10/2/02", n, seconds_left, time_bcd); failures++;
    end
    wait_for_tick(n);
    checks++;
    if (n !== 10 || seconds_left !== 7'd1) begin
      $display("FAIL tick_to_1 cycles=%0d sec=%0d exp=10/1", n, seconds_left); failures++;
    end
    wait_for_tick(n);
    checks++;
    if (n !== 10 || seconds_left !== 7'd0 || end_of_time !== 1'b0) begin
      $display("FAIL tick_to_0 cycles=%0d sec=%0d eot=%b exp=10/0/0", n, seconds_left, end_of_time); failures++;
    end
    step();
    checks++;
    if (end_of_time !== 1'b1 || sec_tick !== 1'b0) begin
      $display("FAIL eot_after_zero eot=%b tick=%b exp=1/0", end_of_time, sec_tick); failures++;
    end
  endtask

  task automatic test_clamp_and_borrow();
    int n;
    enter_game(7'd120);
    checks++;
    if (seconds_left !== 7'd99 || time_bcd !== 8'h99) begin
      $display("FAIL clamp got=%0d/%h exp=99/99", seconds_left, time_bcd); failures++;
    end
    wait_for_tick(n);
    checks++;
    if (seconds_left !== 7'd98 || time_bcd !== 8'h98) begin
      $display("FAIL first_tick got=%0d/%h exp=98/98", seconds_left, time_bcd); failures++;
    end
    for (int i = 0; i < 8; i++) wait_for_tick(n);
    checks++;
    if (seconds_left !== 7'd90 || time_bcd !== 8'h90) begin
      $display("FAIL ninth_tick got=%0d/%h exp=90/90", seconds_left, time_bcd); failures++;
    end
    wait_for_tick(n);
    checks++;
    if (seconds_left !== 7'd89 || time_bcd !== 8'h89) begin
      $display("FAIL borrow got=%0d/%h exp=89/89", seconds_left, time_bcd); failures++;
    end
  endtask

  task automatic test_leave_game();
    int n;
    enter_game(7'd9);
    wait_for_tick(n);
    wait_for_tick(n);
    checks++;
    if (seconds_left !== 7'd7) begin
      $display("FAIL pre_leave got=%0d exp=7", seconds_left); failures++;
    end
    state_in = c_SCORE;
    step();
    checks++;
    if ({end_of_time, sec_tick, seconds_left, time_bcd} !== 17'd0) begin
      $display("FAIL leave_clear got=%h exp=0", {end_of_time, sec_tick, seconds_left, time_bcd}); failures++;
    end
    time_in  = 7'd4;
    state_in = c_GAME;
    step();
    checks++;
    if (seconds_left !== 7'd0) begin
      $display("FAIL reentry_load_cycle got=%0d exp=0", seconds_left); failures++;
    end
    step();
    checks++;
    if (seconds_left !== 7'd4 || time_bcd !== 8'h04) begin
      $display("FAIL reentry_reload got=%0d/%h exp=4/04", seconds_left, time_bcd); failures++;
    end
  endtask

  task automatic test_zero_time();
    int ticks;
    time_in  = 7'd0;
    state_in = c_IDLE;
    step();
    state_in = c_GAME;
    step();
    step();
    checks++;
    if (end_of_time !== 1'b0 || seconds_left !== 7'd0) begin
      $display("FAIL zero_early eot=%b sec=%0d exp=0/0", end_of_time, seconds_left); failures++;
    end
    step();
    checks++;
    if (end_of_time !== 1'b1) begin
      $display("FAIL zero_eot got=%b exp=1", end_of_time); failures++;
    end
    ticks = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (sec_tick) ticks++;
    end
    checks++;
    if (ticks !== 0 || end_of_time !== 1'b1 || seconds_left !== 7'd0) begin
      $display("FAIL zero_no_tick ticks=%0d eot=%b sec=%0d exp=0/1/0", ticks, end_of_time, seconds_left); failures++;
    end
  endtask

  task automatic test_duck();
    int n;
    logic [6:0] exp_sat;
    logic [6:0] exp_hit;
    logic       exp_eot;
`ifdef GAME_BONUS_EN
    exp_sat = 7'd99; exp_hit = 7'd5; exp_eot = 1'b0;
`else
    exp_sat = 7'd96; exp_hit = 7'd0; exp_eot = 1'b1;
`endif
    enter_game(7'd96);
    clicked_duck = 1'b1;
    step();
    clicked_duck = 1'b0;
    checks++;
    if (seconds_left !== exp_sat || time_bcd !== ((exp_sat == 7'd99) ? 8'h99 : 8'h96)) begin
      $display("FAIL duck_sat got=%0d/%h exp=%0d", seconds_left, time_bcd, exp_sat); failures++;
    end
    enter_game(7'd1);
    for (int i = 0; i < 9; i++) step();
    clicked_duck = 1'b1;
    step();
    clicked_duck = 1'b0;
    checks++;
    if (sec_tick !== 1'b1 || seconds_left !== exp_hit || time_bcd !== ((exp_hit == 7'd5) ? 8'h05 : 8'h00)) begin
      $display("FAIL duck_on_tick tick=%b sec=%0d bcd=%h exp=1/%0d", sec_tick, seconds_left, time_bcd, exp_hit); failures++;
    end
    step();
    checks++;
    if (end_of_time !== exp_eot) begin
      $display("FAIL duck_eot got=%b exp=%b", end_of_time, exp_eot); failures++;
    end
  endtask

  task automatic test_reset_mid_run();
    int ticks;
    enter_game(7'd20);
    for (int i = 0; i < 5; i++) step();
    rst_d = 1'b1;
    step();
    rst_d = 1'b0;
    checks++;
    if ({end_of_time, sec_tick, seconds_left, time_bcd} !== 17'd0) begin
      $display("FAIL midrun_reset got=%h exp=0", {end_of_time, sec_tick, seconds_left, time_bcd}); failures++;
    end
    ticks = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (sec_tick || seconds_left != 7'd0) ticks++;
    end
    checks++;
    if (ticks !== 0) begin
      $display("FAIL no_reload_after_reset activity=%0d exp=0", ticks); failures++;
    end
    enter_game(7'd20);
    checks++;
    if (seconds_left !== 7'd20 || time_bcd !== 8'h20) begin
      $display("FAIL fresh_entry got=%0d/%h exp=20/20", seconds_left, time_bcd); failures++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_countdown();
    test_clamp_and_borrow();
    test_leave_game();
    test_zero_time();
    test_duck();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
